// File: rtl/wish_pkg.sv
// Shared definitions for the wish_pack width up-converter: tag bit indices,
// FSM state encoding and lane ordering.
package wish_pkg;

  localparam int unsigned TGC_FIRST = 0;
  localparam int unsigned TGC_LAST  = 1;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } pack_state_e;

  // Lane that beat number 'beat' of a word occupies (lane 0 = least significant).
  function automatic int unsigned lane_index(input int unsigned beat,
                                             input int unsigned num_pack,
                                             input bit          little_endian);
    return little_endian ? beat : (num_pack - 1 - beat);
  endfunction

endpackage

// File: rtl/wish_pack_if.sv
// Narrow source bus plus wide sink bus seen by wish_pack; the slave modport is
// the packer's view, the master modport the surrounding producer/consumer view.
interface wish_pack_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PACK   = 4,
  parameter int unsigned TGC_WIDTH  = 2
);
  logic                           s_cyc_i;
  logic                           s_stb_i;
  logic [DATA_WIDTH-1:0]          s_dat_i;
  logic [TGC_WIDTH-1:0]           s_tgc_i;
  logic                           s_ack_o;
  logic                           s_stall_o;
  logic                           d_cyc_o;
  logic                           d_stb_o;
  logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o;
  logic [TGC_WIDTH-1:0]           d_tgc_o;
  logic [NUM_PACK-1:0]            d_sel_o;
  logic                           d_ack_i;

  modport slave (
    input  s_cyc_i, s_stb_i, s_dat_i, s_tgc_i, d_ack_i,
    output s_ack_o, s_stall_o, d_cyc_o, d_stb_o, d_dat_o, d_tgc_o, d_sel_o
  );

  modport master (
    output s_cyc_i, s_stb_i, s_dat_i, s_tgc_i, d_ack_i,
    input  s_ack_o, s_stall_o, d_cyc_o, d_stb_o, d_dat_o, d_tgc_o, d_sel_o
  );
endinterface

// File: rtl/wish_out_reg.sv
// Single-entry stb/ack holding register for a completed wide word; a load and
// a drain may happen in the same cycle without a bubble.
module wish_out_reg #(
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned TGC_WIDTH = 2,
  parameter int unsigned SEL_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DAT_WIDTH-1:0] load_dat_i,
  input  logic [TGC_WIDTH-1:0] load_tgc_i,
  input  logic [SEL_WIDTH-1:0] load_sel_i,
  input  logic                 ack_i,
  output logic                 stb_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic [TGC_WIDTH-1:0] tgc_o,
  output logic [SEL_WIDTH-1:0] sel_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_o <= 1'b0;
      dat_o <= '0;
      tgc_o <= '0;
      sel_o <= '0;
    end else if (load_i) begin
      stb_o <= 1'b1;
      dat_o <= load_dat_i;
      tgc_o <= load_tgc_i;
      sel_o <= load_sel_i;
    end else if (stb_o && ack_i) begin
      stb_o <= 1'b0;
    end
  end

endmodule

// File: rtl/wish_pack.sv
// Width up-converter: packs NUM_PACK narrow beats into one wide word, keeping
// first/last framing and flushing zero-padded partial words at packet end.
module wish_pack
  import wish_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_PACK      = 4,
  parameter int unsigned TGC_WIDTH     = 2,
  parameter int unsigned LITTLE_ENDIAN = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wish_pack_if.slave  bus
);

  localparam int unsigned CNT_W  = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
  localparam int unsigned WIDE_W = DATA_WIDTH * NUM_PACK;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_PACK - 1);
  localparam bit LE = (LITTLE_ENDIAN != 0);

  logic                 out_valid;
  logic [WIDE_W-1:0]    out_dat;
  logic [TGC_WIDTH-1:0] out_tgc;
  logic [NUM_PACK-1:0]  out_sel;

  logic [CNT_W-1:0]     lane_cnt;
  logic [CNT_W-1:0]     beat_pos;
  logic [WIDE_W-1:0]    acc_dat;
  logic [NUM_PACK-1:0]  acc_sel;
  logic [TGC_WIDTH-1:0] acc_tgc;

  logic [WIDE_W-1:0]    word_dat;
  logic [NUM_PACK-1:0]  word_sel;
  logic [TGC_WIDTH-1:0] word_tgc;

  logic beat_first;
  logic beat_last;
  logic s_xfer;
  logic word_done;
  logic drain;

  pack_state_e state, state_nxt;

  assign beat_first = bus.s_tgc_i[TGC_FIRST];
  assign beat_last  = bus.s_tgc_i[TGC_LAST];

  // Only a beat that would complete a word needs the output register free.
  assign bus.s_stall_o = out_valid & ~bus.d_ack_i & ((lane_cnt == LAST_LANE) | beat_last);
  assign bus.s_ack_o   = bus.s_cyc_i & bus.s_stb_i & ~bus.s_stall_o & ~rst_i;

  assign s_xfer    = bus.s_cyc_i & bus.s_stb_i & bus.s_ack_o;
  assign beat_pos  = beat_first ? '0 : lane_cnt;
  assign word_done = s_xfer & ((beat_pos == LAST_LANE) | beat_last);
  assign drain     = out_valid & bus.d_ack_i;

  // A first flag restarts the word: the stale partial contents are not merged.
  always_comb begin
    word_dat = beat_first ? '0 : acc_dat;
    word_sel = beat_first ? '0 : acc_sel;
    word_tgc = (beat_pos == '0) ? bus.s_tgc_i : acc_tgc;
    for (int unsigned i = 0; i < NUM_PACK; i++) begin
      if (i == lane_index(32'(beat_pos), NUM_PACK, LE)) begin
        word_dat[i*DATA_WIDTH +: DATA_WIDTH] = bus.s_dat_i;
        word_sel[i]                          = 1'b1;
      end
    end
    word_tgc[TGC_LAST] = beat_last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_cnt <= '0;
      acc_dat  <= '0;
      acc_sel  <= '0;
      acc_tgc  <= '0;
    end else if (s_xfer) begin
      if (word_done) begin
        lane_cnt <= '0;
        acc_dat  <= '0;
        acc_sel  <= '0;
        acc_tgc  <= '0;
      end else begin
        lane_cnt <= beat_pos + 1'b1;
        acc_dat  <= word_dat;
        acc_sel  <= word_sel;
        acc_tgc  <= word_tgc;
      end
    end
  end

  wish_out_reg #(
    .DAT_WIDTH (WIDE_W),
    .TGC_WIDTH (TGC_WIDTH),
    .SEL_WIDTH (NUM_PACK)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (word_done),
    .load_dat_i (word_dat),
    .load_tgc_i (word_tgc),
    .load_sel_i (word_sel),
    .ack_i      (bus.d_ack_i),
    .stb_o      (out_valid),
    .dat_o      (out_dat),
    .tgc_o      (out_tgc),
    .sel_o      (out_sel)
  );

  assign bus.d_stb_o = out_valid;
  assign bus.d_dat_o = out_dat;
  assign bus.d_tgc_o = out_tgc;
  assign bus.d_sel_o = out_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.d_cyc_o = (state == ST_ACTIVE) | out_valid;
    case (state)
      ST_IDLE: begin
        if (s_xfer) begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (drain && out_tgc[TGC_LAST] && !s_xfer) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
